// File: rtl/logic_unit_arbiter.sv
// Two-requester bitwise logic unit (OR/AND/XOR/NOR) with a round-robin arbiter and IDLE/EXEC/DONE FSM.
// Optional registered zero flag is enabled by defining LOGIC_ARB_ZFLAG_EN.
module logic_unit_arbiter #(
    parameter int k = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic [1:0]   op0,
    input  logic [k-1:0] a0,
    input  logic [k-1:0] b0,
    input  logic         req1,
    input  logic [1:0]   op1,
    input  logic [k-1:0] a1,
    input  logic [k-1:0] b1,
    output logic         done0,
    output logic         done1,
    output logic [k-1:0] result,
    output logic         busy
`ifdef LOGIC_ARB_ZFLAG_EN
    ,
    output logic         zero
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    state_e       state_q, state_d;
    logic         gnt_q, gnt_d;
    logic         last_q, last_d;
    logic [1:0]   op_q, op_d;
    logic [k-1:0] a_q, a_d;
    logic [k-1:0] b_q, b_d;
    logic [k-1:0] result_q, result_d;

    function automatic logic [k-1:0] apply_op(input logic [1:0] op,
                                              input logic [k-1:0] a,
                                              input logic [k-1:0] b);
        logic [k-1:0] r;
        case (op_e'(op))
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On contention the requester not served last wins.
                    gnt_d   = (req0 && req1) ? ~last_q : req1;
                    op_d    = gnt_d ? op1 : op0;
                    a_d     = gnt_d ? a1  : a0;
                    b_d     = gnt_d ? b1  : b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = apply_op(op_q, a_q, b_q);
                state_d  = DONE;
            end
            DONE: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            op_q     <= 2'b00;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign done0  = (state_q == DONE) && !gnt_q;
    assign done1  = (state_q == DONE) &&  gnt_q;
    assign busy   = (state_q != IDLE);
    assign result = result_q;

`ifdef LOGIC_ARB_ZFLAG_EN
    logic zero_q, zero_d;

    always_comb begin
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed and randomised self-checking bench for logic_unit_arbiter.
// Zero-flag checks are compiled in when LOGIC_ARB_ZFLAG_EN is defined.
module tb_logic_unit_arbiter;

    localparam int K = 16;

    logic         clk;
    logic         rst_n;
    logic         req0, req1;
    logic [1:0]   op0, op1;
    logic [K-1:0] a0, b0, a1, b1;
    logic         done0, done1, busy;
    logic [K-1:0] result;
`ifdef LOGIC_ARB_ZFLAG_EN
    logic         zero;
`endif

    int n_checks;
    int n_errors;

    logic_unit_arbiter #(.k(K)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .op0    (op0),
        .a0     (a0),
        .b0     (b0),
        .req1   (req1),
        .op1    (op1),
        .a1     (a1),
        .b1     (b1),
        .done0  (done0),
        .done1  (done1),
        .result (result),
        .busy   (busy)
`ifdef LOGIC_ARB_ZFLAG_EN
        ,
        .zero   (zero)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [K-1:0] ref_op(input logic [1:0] op, input logic [K-1:0] a,
                                            input logic [K-1:0] b);
        case (op)
            2'b00:   ref_op = a | b;
            2'b01:   ref_op = a & b;
            2'b10:   ref_op = a ^ b;
            default: ref_op = ~(a | b);
        endcase
    endfunction

    initial begin
        logic         last_m;
        logic         g;
        logic [1:0]   rq;
        logic [K-1:0] exp_r;
        int           cnt0, cnt1, diff;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        op0 = 2'b00; op1 = 2'b00;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        // Reset state
        #2;
        check("rst_busy",   busy,   0);
        check("rst_result", result, 0);
        check("rst_done0",  done0,  0);
        check("rst_done1",  done1,  0);
`ifdef LOGIC_ARB_ZFLAG_EN
        check("rst_zero",   zero,   1);
`endif
        step();
        rst_n = 1'b1;

        // req0 OR: F0F0 | 0F0F = FFFF, accepted at the first edge after reset release
        req0 = 1'b1; op0 = 2'b00; a0 = 16'hF0F0; b0 = 16'h0F0F;
        step();
        req0 = 1'b0;
        check("t1_busy_exec",  busy,  1);
        check("t1_done0_exec", done0, 0);
        step();
        check("t1_result", result, 16'hFFFF);
        check("t1_done0",  done0,  1);
        check("t1_done1",  done1,  0);
        check("t1_busy",   busy,   1);
`ifdef LOGIC_ARB_ZFLAG_EN
        check("t1_zero",   zero,   0);
`endif
        step();
        check("t1_done0_off", done0,  0);
        check("t1_idle",      busy,   0);
        check("t1_hold",      result, 16'hFFFF);

        // req1 NOR: ~(FFFF | 0000) = 0000
        req1 = 1'b1; op1 = 2'b11; a1 = 16'hFFFF; b1 = 16'h0000;
        step();
        req1 = 1'b0;
        step();
        check("t2_result", result, 16'h0000);
        check("t2_done1",  done1,  1);
        check("t2_done0",  done0,  0);
`ifdef LOGIC_ARB_ZFLAG_EN
        check("t2_zero",   zero,   1);
`endif
        step();
        check("t2_done1_off", done1, 0);

        // Dual requests held from reset: 0 wins first, then alternate every 3 cycles
        rst_n = 1'b0;
        #1;
        req0 = 1'b1; op0 = 2'b01; a0 = 16'h00FF; b0 = 16'h0F0F;
        req1 = 1'b1; op1 = 2'b10; a1 = 16'hAAAA; b1 = 16'hFFFF;
        rst_n = 1'b1;
        step();
        check("t3_busy_e0", busy, 1);
        step();
        check("t3_res_a",   result, 16'h000F);
        check("t3_done0_a", done0,  1);
        check("t3_done1_a", done1,  0);
        step();
        check("t3_idle_e2", busy,  0);
        check("t3_gap0",    done0, 0);
        step();
        check("t3_busy_e3", busy,  1);
        check("t3_gap1",    done1, 0);
        step();
        check("t3_res_b",   result, 16'h5555);
        check("t3_done1_b", done1,  1);
        check("t3_done0_b", done0,  0);
        step();
        step();
        step();
        check("t3_res_c",   result, 16'h000F);
        check("t3_done0_c", done0,  1);
        check("t3_done1_c", done1,  0);
        req0 = 1'b0; req1 = 1'b0;
        step();
        check("t3_idle_end", busy, 0);

        // Operand change during EXEC must not affect the in-flight result
        req0 = 1'b1; op0 = 2'b00; a0 = 16'h1234; b0 = 16'h0000;
        step();
        req0 = 1'b0; a0 = 16'hFFFF;
        step();
        check("t4_result", result, 16'h1234);
        check("t4_done0",  done0,  1);
        step();

        // Reset during EXEC aborts with no done pulse
        req0 = 1'b1; op0 = 2'b01; a0 = 16'hFFFF; b0 = 16'hFFFF;
        step();
        req0 = 1'b0;
        check("t5_busy_exec", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_busy_rst",   busy,   0);
        check("t5_result_rst", result, 0);
        check("t5_done0_rst",  done0,  0);
        step();
        check("t5_done0_held", done0, 0);
        check("t5_done1_held", done1, 0);
        rst_n = 1'b1;
        step();
        check("t5_no_done", done0, 0);
        check("t5_idle",    busy,  0);

        // First request after reset release: req1 XOR 00F0 ^ 0FF0 = 0F00
        req1 = 1'b1; op1 = 2'b10; a1 = 16'h00F0; b1 = 16'h0FF0;
        step();
        req1 = 1'b0;
        step();
        check("t6_result", result, 16'h0F00);
        check("t6_done1",  done1,  1);
        step();

        // Randomised transactions; grants modelled from the round-robin rule
        last_m = 1'b1;
        cnt0 = 0;
        cnt1 = 0;
        for (int t = 0; t < 400; t++) begin
            rq   = (t >= 200) ? 2'b11 : 2'($urandom_range(1, 3));
            req0 = rq[0]; req1 = rq[1];
            op0  = 2'($urandom); op1 = 2'($urandom);
            a0   = K'($urandom); b0 = K'($urandom);
            a1   = K'($urandom); b1 = K'($urandom);
            g     = (rq == 2'b11) ? ~last_m : rq[1];
            exp_r = g ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
            step();
            // Scramble inputs while busy; they must be ignored
            op0 = 2'($urandom); op1 = 2'($urandom);
            a0  = K'($urandom); b0 = K'($urandom);
            a1  = K'($urandom); b1 = K'($urandom);
            if (t < 200) begin
                req0 = 1'($urandom); req1 = 1'($urandom);
            end
            step();
            check("rnd_result", result, exp_r);
            check("rnd_done0",  done0,  !g);
            check("rnd_done1",  done1,  g);
`ifdef LOGIC_ARB_ZFLAG_EN
            check("rnd_zero",   zero,   exp_r == '0);
`endif
            step();
            check("rnd_idle", {busy, done0, done1}, 0);
            last_m = g;
            if (t >= 200) begin
                if (g) cnt1++;
                else   cnt0++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        diff = (cnt0 > cnt1) ? cnt0 - cnt1 : cnt1 - cnt0;
        check("fairness", diff <= 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Completion pulses must be mutually exclusive
    always @(negedge clk) begin
        if (rst_n && done0 && done1) begin
            check("done_exclusive", {done0, done1}, 2'b00);
        end
    end

endmodule
